// File: rtl/nibble_dp_arbiter.sv
// Round-robin arbiter that shares one multi-cycle datapath between two requesters,
// waits for done (or a timeout) and returns the result tagged with the requester id.
module nibble_dp_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] dp_a,
  output logic             dp_start,
  input  logic             dp_done,
  input  logic [WIDTH-1:0] dp_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_nextState;
  logic             r_rrPtr, w_rrPtr;
  logic             r_owner, w_owner;
  logic [TW-1:0]    r_timer, w_timer;
  logic [WIDTH-1:0] r_dpA, w_dpA;
  logic             r_gnt0, w_gnt0;
  logic             r_gnt1, w_gnt1;
  logic             r_dpStart, w_dpStart;
  logic             r_rspValid, w_rspValid;
  logic             r_rspId, w_rspId;
  logic [WIDTH-1:0] r_rspData, w_rspData;
  logic             r_rspErr, w_rspErr;

  logic w_anyReq;
  logic w_sel;
  logic w_timeout;

  // A lone requester wins outright; on contention the round-robin pointer decides.
  assign w_anyReq  = req0 | req1;
  assign w_sel     = (req0 & req1) ? r_rrPtr : req1;
  assign w_timeout = (r_timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rrPtr    <= 1'b0;
      r_owner    <= 1'b0;
      r_timer    <= '0;
      r_dpA      <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_dpStart  <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspId    <= 1'b0;
      r_rspData  <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_rrPtr    <= w_rrPtr;
      r_owner    <= w_owner;
      r_timer    <= w_timer;
      r_dpA      <= w_dpA;
      r_gnt0     <= w_gnt0;
      r_gnt1     <= w_gnt1;
      r_dpStart  <= w_dpStart;
      r_rspValid <= w_rspValid;
      r_rspId    <= w_rspId;
      r_rspData  <= w_rspData;
      r_rspErr   <= w_rspErr;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_anyReq) w_nextState = S_WAIT;
      S_WAIT:  if (dp_done || w_timeout) w_nextState = S_RESP;
      S_RESP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; done is checked before the timeout so it wins a tie.
  always_comb begin
    w_rrPtr    = r_rrPtr;
    w_owner    = r_owner;
    w_timer    = r_timer;
    w_dpA      = r_dpA;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_dpStart  = 1'b0;
    w_rspValid = 1'b0;
    w_rspId    = r_rspId;
    w_rspData  = r_rspData;
    w_rspErr   = r_rspErr;
    case (r_state)
      S_IDLE: begin
        if (w_anyReq) begin
          w_dpA     = w_sel ? a1 : a0;
          w_gnt0    = ~w_sel;
          w_gnt1    = w_sel;
          w_dpStart = 1'b1;
          w_owner   = w_sel;
          w_timer   = '0;
        end
      end
      S_WAIT: begin
        w_timer = r_timer + TW'(1);
        if (dp_done) begin
          w_rspValid = 1'b1;
          w_rspId    = r_owner;
          w_rspData  = dp_result;
          w_rspErr   = 1'b0;
        end else if (w_timeout) begin
          w_rspValid = 1'b1;
          w_rspId    = r_owner;
          w_rspData  = '0;
          w_rspErr   = 1'b1;
        end
      end
      S_RESP: w_rrPtr = ~r_owner;
      default: ;
    endcase
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign dp_a      = r_dpA;
  assign dp_start  = r_dpStart;
  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_rspId;
  assign rsp_data  = r_rspData;
  assign rsp_err   = r_rspErr;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_nibble_dp_arbiter.sv
// Testbench for nibble_dp_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized run against a transaction-level model.
module tb_nibble_dp_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, a1;
  logic       gnt0, gnt1;
  logic [3:0] dp_a;
  logic       dp_start;
  logic       dp_done;
  logic [3:0] dp_result;
  logic       rsp_valid, rsp_id, rsp_err, busy;
  logic [3:0] rsp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_dp_arbiter #(.WIDTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .req1(req1), .a1(a1),
    .gnt0(gnt0), .gnt1(gnt1),
    .dp_a(dp_a), .dp_start(dp_start), .dp_done(dp_done), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  // One row = inputs held for a cycle, outputs expected just after the following edge.
  // exp = {gnt0,gnt1,dp_start,dp_a,rsp_valid,rsp_id,rsp_data,rsp_err,busy}
  typedef struct {
    logic        rst;
    logic        req0;
    logic [3:0]  a0;
    logic        req1;
    logic [3:0]  a1;
    logic        done;
    logic [3:0]  res;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input int r, input int q0, input int x0, input int q1, input int x1,
                        input int d, input int rs, input int g0, input int g1, input int st,
                        input int dpa, input int rv, input int rid, input int rd, input int re,
                        input int bsy);
    vec_t v;
    v.rst  = r[0];
    v.req0 = q0[0];
    v.a0   = x0[3:0];
    v.req1 = q1[0];
    v.a1   = x1[3:0];
    v.done = d[0];
    v.res  = rs[3:0];
    v.exp  = {g0[0], g1[0], st[0], dpa[3:0], rv[0], rid[0], rd[3:0], re[0], bsy[0]};
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    req0      = v.req0;
    a0        = v.a0;
    req1      = v.req1;
    a1        = v.a1;
    dp_done   = v.done;
    dp_result = v.res;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0;
    dp_done = 1'b0; dp_result = '0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] dpModel(input logic [3:0] a);
    return 4'(a * 3 + 1);
  endfunction

  task automatic testBothFromReset();
    int grants, resps, doneAt;
    logic [3:0] order;
    logic lastId;
    order = 4'b1010;
    grants = 0; resps = 0; doneAt = -1; lastId = 1'b0;
    doReset();
    req0 = 1'b1; a0 = 4'h3; req1 = 1'b1; a1 = 4'hC;
    for (int c = 0; c < 100 && resps < 4; c++) begin
      tick();
      dp_done = 1'b0;
      if ((gnt0 || gnt1) && grants < 4) begin
        checkOutput($sformatf("t2 grant%0d id", grants), 32'(gnt1), 32'(order[grants]));
        checkOutput($sformatf("t2 grant%0d dp_a", grants), 32'(dp_a), order[grants] ? 32'hC : 32'h3);
        lastId = order[grants];
        grants++;
        doneAt = c + 1;
      end
      if (c == doneAt) begin
        dp_done = 1'b1;
        dp_result = 4'(c);
      end
      if (rsp_valid) begin
        checkOutput("t2 rsp id", 32'(rsp_id), 32'(lastId));
        resps++;
      end
    end
    checkOutput("t2 responses", 32'(resps), 32'd4);
  endtask

  task automatic testTimeout();
    int startC, rspC;
    logic [5:0] fields;
    startC = -1; rspC = -1; fields = '0;
    doReset();
    req1 = 1'b1; a1 = 4'h6;
    for (int c = 0; c < 60 && rspC < 0; c++) begin
      tick();
      if (dp_start && startC < 0) begin
        startC = c;
        req1 = 1'b0;
      end
      if (rsp_valid) begin
        rspC = c;
        fields = {rsp_id, rsp_data, rsp_err};
      end
    end
    checkOutput("t3 start-to-rsp cycles", 32'(rspC - startC), 32'd15);
    checkOutput("t3 {id,data,err}", 32'(fields), 32'({1'b1, 4'h0, 1'b1}));
  endtask

  task automatic testBackToBack();
    int g[3];
    int grants, idleCnt, g1Cnt, doneAt;
    g = '{0, 0, 0};
    grants = 0; idleCnt = 0; g1Cnt = 0; doneAt = -1;
    doReset();
    req0 = 1'b1; a0 = 4'h9;
    for (int c = 0; c < 100 && grants < 3; c++) begin
      tick();
      dp_done = 1'b0;
      if (gnt1) g1Cnt++;
      if (gnt0) begin
        g[grants] = c;
        grants++;
        doneAt = c + 2;
      end else if (grants > 0 && !busy) begin
        idleCnt++;
      end
      if (c == doneAt) begin
        dp_done = 1'b1;
        dp_result = 4'h4;
      end
    end
    req0 = 1'b0;
    checkOutput("t6 grants", 32'(grants), 32'd3);
    checkOutput("t6 spacing 0-1", 32'(g[1] - g[0]), 32'd5);
    checkOutput("t6 spacing 1-2", 32'(g[2] - g[1]), 32'd5);
    checkOutput("t6 idle cycles", 32'(idleCnt), 32'd2);
    checkOutput("t6 gnt1 pulses", 32'(g1Cnt), 32'd0);
  endtask

  // Transaction-level model: a grant follows any idle cycle with a request, the response
  // lands latency+1 cycles after start (or 15 on timeout), and the DUT is idle from the
  // cycle after the response until the next grant.
  task automatic runRandom(input int cycles);
    int rspAt, doneAt, lat;
    bit mIdle, pendG, pendSel, rr, owner, expRid, expRe, inResp, r0, r1;
    logic [3:0] ownerA, expRd, op0, op1;
    mIdle = 1'b1; pendG = 1'b0; pendSel = 1'b0; rr = 1'b0; owner = 1'b0;
    expRid = 1'b0; expRe = 1'b0; r0 = 1'b0; r1 = 1'b0;
    ownerA = '0; expRd = '0; op0 = '0; op1 = '0;
    rspAt = -1; doneAt = -1;
    doReset();
    for (int c = 1; c <= cycles; c++) begin
      tick();
      if (pendG) mIdle = 1'b0;
      else if (rspAt == c - 1) mIdle = 1'b1;
      inResp = (c == rspAt);

      checkOutput("rnd {gnt0,gnt1,dp_start}", 32'({gnt0, gnt1, dp_start}),
                  32'({pendG && !pendSel, pendG && pendSel, pendG}));
      if (pendG) begin
        owner  = pendSel;
        ownerA = pendSel ? op1 : op0;
        lat = $urandom_range(0, 16);
        if (lat >= 15) begin
          doneAt = -1;
          rspAt  = c + 15;
        end else begin
          doneAt = c + lat;
          rspAt  = c + lat + 1;
        end
        if ($urandom_range(0, 1) == 1) begin
          if (pendSel) op1 = 4'($urandom); else op0 = 4'($urandom);
        end else begin
          if (pendSel) r1 = 1'b0; else r0 = 1'b0;
        end
      end
      checkOutput("rnd busy", 32'(busy), 32'(!mIdle));
      checkOutput("rnd dp_a", 32'(dp_a), 32'(ownerA));
      if (inResp) begin
        rr     = ~owner;
        expRid = owner;
        expRe  = (doneAt < 0);
        expRd  = expRe ? 4'h0 : dpModel(ownerA);
      end
      checkOutput("rnd {rsp_valid,rsp_id,rsp_data,rsp_err}",
                  32'({rsp_valid, rsp_id, rsp_data, rsp_err}),
                  32'({inResp, expRid, expRd, expRe}));

      // Stray done pulses outside WAIT must be ignored.
      if (c == doneAt) begin
        dp_done = 1'b1;
        dp_result = dpModel(ownerA);
      end else begin
        dp_done = (mIdle || inResp) ? 1'($urandom_range(0, 1)) : 1'b0;
        dp_result = 4'($urandom);
      end
      if (!r0 && $urandom_range(0, 3) == 0) begin r0 = 1'b1; op0 = 4'($urandom); end
      if (!r1 && $urandom_range(0, 3) == 0) begin r1 = 1'b1; op1 = 4'($urandom); end
      req0 = r0; a0 = op0; req1 = r1; a1 = op1;
      pendG   = mIdle && (r0 || r1);
      pendSel = (r0 && r1) ? rr : r1;
    end
  endtask

  initial begin
    // rst req0 a0 req1 a1 done res | gnt0 gnt1 start dp_a valid id data err busy
    addVec(1, 0, 0,   0, 0,   0, 0,     0, 0, 0, 0,   0, 0, 0,   0, 0);
    addVec(0, 1, 5,   0, 0,   0, 0,     1, 0, 1, 5,   0, 0, 0,   0, 1);
    for (int k = 0; k < 3; k++)
      addVec(0, 0, 5, 0, 0,   0, 0,     0, 0, 0, 5,   0, 0, 0,   0, 1);
    addVec(0, 0, 5,   0, 0,   1, 'hA,   0, 0, 0, 5,   1, 0, 'hA, 0, 1);
    addVec(0, 0, 5,   0, 0,   0, 0,     0, 0, 0, 5,   0, 0, 'hA, 0, 0);
    addVec(0, 0, 0,   0, 0,   1, 'hF,   0, 0, 0, 5,   0, 0, 'hA, 0, 0);
    addVec(0, 1, 7,   0, 0,   0, 0,     1, 0, 1, 7,   0, 0, 'hA, 0, 1);
    for (int k = 0; k < 14; k++)
      addVec(0, 0, 7, 0, 0,   0, 0,     0, 0, 0, 7,   0, 0, 'hA, 0, 1);
    addVec(0, 0, 7,   0, 0,   1, 3,     0, 0, 0, 7,   1, 0, 3,   0, 1);
    addVec(0, 0, 0,   0, 0,   1, 'hE,   0, 0, 0, 7,   0, 0, 3,   0, 0);
    addVec(0, 0, 0,   0, 0,   1, 'hE,   0, 0, 0, 7,   0, 0, 3,   0, 0);
    addVec(0, 0, 0,   1, 'hC, 0, 0,     0, 1, 1, 'hC, 0, 0, 3,   0, 1);
    addVec(0, 0, 0,   0, 'hC, 0, 0,     0, 0, 0, 'hC, 0, 0, 3,   0, 1);
    addVec(1, 1, 3,   1, 'hC, 0, 0,     0, 0, 0, 0,   0, 0, 0,   0, 0);
    addVec(0, 1, 3,   1, 'hC, 0, 0,     1, 0, 1, 3,   0, 0, 0,   0, 1);
    addVec(0, 0, 3,   1, 'hC, 1, 6,     0, 0, 0, 3,   1, 0, 6,   0, 1);
    addVec(0, 0, 3,   1, 'hC, 0, 0,     0, 0, 0, 3,   0, 0, 6,   0, 0);
    addVec(0, 0, 3,   1, 'hC, 0, 0,     0, 1, 1, 'hC, 0, 0, 6,   0, 1);
    addVec(0, 0, 3,   0, 'hC, 1, 9,     0, 0, 0, 'hC, 1, 1, 9,   0, 1);
    addVec(0, 0, 0,   0, 0,   0, 0,     0, 0, 0, 'hC, 0, 1, 9,   0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d outputs", i),
                  {17'b0, gnt0, gnt1, dp_start, dp_a, rsp_valid, rsp_id, rsp_data, rsp_err, busy},
                  {17'b0, vecs[i].exp});
    end

    testBothFromReset();
    testTimeout();
    testBackToBack();
    runRandom(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
